seg7_scan_driver: RTL

Time-multiplexed 4-digit 7-segment driver that consumes the processor's 16-bit result bus and drives the board's segment/anode lines. It captures the result on a load strobe, holds it in a shadow register, and scans one hex digit at a time at a prescaled refresh rate. Optional leading-zero blanking and per-digit decimal points are supported. Sits directly downstream of the processor top.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_hex_decode.sv | 16 +
 rtl/seg7_scan_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, hex glyph table and display payload type for the
// 4-digit multiplexed 7-segment scan driver.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned DIG_W      = 2;
    localparam int unsigned VAL_W      = NUM_DIGITS * NIB_W;

    // All segments off (segments are active-low).
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs as {g,f,e,d,c,b,a}; b and d are lowercase.
    localparam logic [SEG_W-1:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    // Registered display payload driven onto the board pins.
    typedef struct packed {
        logic [SEG_W-1:0]      seg;
        logic                  dp;
        logic [NUM_DIGITS-1:0] an;
    } disp_t;

    localparam disp_t DISP_RESET = '{seg: SEG_BLANK, dp: 1'b1, an: 4'hF};

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to active-low 7-segment glyph decoder.
// Ports:
//   nib   - 4-bit hex digit
//   seg_c - segments {g,f,e,d,c,b,a}, active-low (combinational)
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = HEX_GLYPH[nib];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver. Captures a 16-bit value and
// per-digit decimal points on load, scans one digit per 2^DIV_W clocks with
// an anti-ghost guard window and optional leading-zero blanking.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   value_in  - value to display, nibble k on digit k (digit 0 rightmost)
//   load      - capture strobe for value_in / dp_in
//   dp_in     - decimal-point request per digit, 1 = lit
//   blank_lz  - 1 = blank leading zero digits (digit 0 always shown)
//   seg       - segments {g..a}, active-low, registered
//   dp        - decimal point, active-low, registered
//   an        - digit anodes, active-low, registered
// GUARD must be smaller than 2^DIV_W or the anodes never light.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned GUARD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VAL_W-1:0]      value_in,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  blank_lz,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    logic [DIV_W-1:0]      pre_q;
    logic [DIG_W-1:0]      dig_q;
    logic [VAL_W-1:0]      val_q;
    logic [NUM_DIGITS-1:0] dp_q;
    disp_t                 disp_q;

    logic [NIB_W-1:0]      nib_c;
    logic [SEG_W-1:0]      glyph_c;
    logic [NUM_DIGITS-1:0] nz_c;
    logic [NUM_DIGITS-1:0] lz_c;
    logic                  guard_c;
    disp_t                 disp_d_c;

    // Shadow registers: hold the captured value between loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            dp_q  <= '0;
        end else if (load) begin
            val_q <= value_in;
            dp_q  <= dp_in;
        end
    end

    // Free-running prescaler; the digit index advances on its wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            dig_q <= '0;
        end else begin
            pre_q <= pre_q + DIV_W'(1);
            if (&pre_q) begin
                dig_q <= dig_q + DIG_W'(1);
            end
        end
    end

    // Nibble shown on the active digit.
    always_comb begin
        nib_c = val_q[3:0];
        case (dig_q)
            2'd0:    nib_c = val_q[3:0];
            2'd1:    nib_c = val_q[7:4];
            2'd2:    nib_c = val_q[11:8];
            default: nib_c = val_q[15:12];
        endcase
    end

    seg7_hex_decode u_dec (
        .nib   (nib_c),
        .seg_c (glyph_c)
    );

    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 never is.
    always_comb begin
        nz_c = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            nz_c[k] = (val_q[k*NIB_W +: NIB_W] == '0);
        end
        lz_c    = '0;
        lz_c[3] = nz_c[3];
        lz_c[2] = nz_c[3] & nz_c[2];
        lz_c[1] = nz_c[3] & nz_c[2] & nz_c[1];
    end

    assign guard_c = (pre_q < DIV_W'(GUARD));

    // Next display word: blanking only affects segments, guard only anodes.
    always_comb begin
        disp_d_c     = DISP_RESET;
        disp_d_c.seg = (blank_lz && lz_c[dig_q]) ? SEG_BLANK : glyph_c;
        disp_d_c.dp  = ~dp_q[dig_q];
        disp_d_c.an  = guard_c ? 4'hF : ~(4'b0001 << dig_q);
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= DISP_RESET;
        end else begin
            disp_q <= disp_d_c;
        end
    end

    assign seg = disp_q.seg;
    assign dp  = disp_q.dp;
    assign an  = disp_q.an;

endmodule
